// File: rtl/pdp6_iob_pkg.sv
// Shared PDP-6 IO bus definitions: device codes, CONI/CONO status
// bit positions and the PIA-to-request decode.
package pdp6_iob_pkg;

    localparam logic [6:0] PTR = 7'o021;

    localparam int ST_BINARY = 30;
    localparam int ST_BUSY   = 31;
    localparam int ST_FLAG   = 32;
    localparam int ST_PIA_HI = 33;
    localparam int ST_PIA_LO = 35;

    localparam int FRAMES_PER_WORD = 6;

    typedef logic [0:35] word_t;
    typedef logic [1:8]  frame_t;
    typedef logic [1:7]  pi_t;

    // PIA 0 means "no channel", so it never raises a request.
    function automatic pi_t pia_decode(input logic [2:0] pia,
                                       input logic req);
        pi_t r;
        r = '0;
        for (int i = 1; i <= 7; i++) begin
            r[i] = req && (pia == 3'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/ptr_asm.sv
// Paper-tape frame assembler: buffer, frame counter, hole-8 filter
// and the one-cycle done pulse that completes a word or character.
module ptr_asm
    import pdp6_iob_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        take,
    input  logic        alpha,
    input  logic [1:8]  frame,
    output logic [0:35] word,
    output logic        done
);

    word_t      word_q, word_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        done   = 1'b0;
        if (clr) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (take) begin
            if (alpha) begin
                word_d = {28'b0, frame};
                done   = 1'b1;
            end else if (frame[1]) begin
                // hole 8 marks a data frame; others are leader/feed
                word_d = {word_q[6:35], frame[3:8]};
                if (cnt_q == 3'(FRAMES_PER_WORD - 1)) begin
                    cnt_d = '0;
                    done  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/ptr_ctl.sv
// PDP-6 paper-tape reader controller (device 104): status, IO decode,
// DATAI restart and PI request. PTR_ALPHA_EN enables alpha mode.
module ptr_ctl
    import pdp6_iob_pkg::*;
#(
    parameter logic [6:0] DEV = PTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iob_reset,
    input  logic [3:9]  iob_ios,
    input  logic        iob_cono_clear,
    input  logic        iob_cono_set,
    input  logic        iob_fm_datai,
    input  logic        iob_fm_status,
    input  logic [0:35] iob_out,
    output logic [0:35] iob_in,
    output logic [1:7]  pi_req,
    input  logic [1:8]  tape_frame,
    input  logic        tape_valid,
    output logic        tape_ready
);

    logic       busy_q, busy_d;
    logic       flag_q, flag_d;
    logic [2:0] pia_q, pia_d;
    logic       datai_q;
    logic       binary;

    logic  rst, sel;
    logic  cono_clr, cono_set, set_busy;
    logic  datai_rd, datai_edge;
    logic  asm_clr, asm_take, asm_done;
    word_t word;

    assign rst        = reset | iob_reset;
    assign sel        = (iob_ios == DEV);
    assign cono_clr   = sel & iob_cono_clear;
    assign cono_set   = sel & iob_cono_set;
    assign set_busy   = cono_set & iob_out[ST_BUSY];
    assign datai_rd   = sel & iob_fm_datai;
    assign datai_edge = datai_rd & ~datai_q;

    assign tape_ready = busy_q & ~flag_q;
    assign asm_clr    = cono_clr | datai_edge | set_busy;
    // A frame loses to any bus command landing in the same cycle.
    assign asm_take   = tape_valid & tape_ready & ~asm_clr & ~cono_set;

`ifdef PTR_ALPHA_EN
    logic binary_q, binary_d;
    logic unused_iob;
    assign binary     = binary_q;
    assign unused_iob = ^iob_out[0:29];
`else
    logic unused_iob;
    assign binary     = 1'b1;
    assign unused_iob = ^{iob_out[0:29], iob_out[ST_BINARY]};
`endif

    always_comb begin
        busy_d = busy_q;
        flag_d = flag_q;
        pia_d  = pia_q;
`ifdef PTR_ALPHA_EN
        binary_d = binary_q;
`endif
        if (cono_clr) begin
            busy_d = 1'b0;
            flag_d = 1'b0;
            pia_d  = '0;
`ifdef PTR_ALPHA_EN
            binary_d = 1'b0;
`endif
        end else if (datai_edge) begin
            busy_d = 1'b1;
            flag_d = 1'b0;
        end else if (cono_set) begin
            busy_d = busy_q | iob_out[ST_BUSY];
            flag_d = flag_q | iob_out[ST_FLAG];
            pia_d  = pia_q | iob_out[ST_PIA_HI:ST_PIA_LO];
`ifdef PTR_ALPHA_EN
            binary_d = binary_q | iob_out[ST_BINARY];
`endif
        end else if (asm_done) begin
            busy_d = 1'b0;
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            flag_q  <= 1'b0;
            pia_q   <= '0;
            datai_q <= 1'b0;
`ifdef PTR_ALPHA_EN
            binary_q <= 1'b0;
`endif
        end else begin
            busy_q  <= busy_d;
            flag_q  <= flag_d;
            pia_q   <= pia_d;
            datai_q <= datai_rd;
`ifdef PTR_ALPHA_EN
            binary_q <= binary_d;
`endif
        end
    end

    ptr_asm u_asm (
        .clk   (clk),
        .reset (rst),
        .clr   (asm_clr),
        .take  (asm_take),
        .alpha (~binary),
        .frame (tape_frame),
        .word  (word),
        .done  (asm_done)
    );

    always_comb begin
        iob_in = '0;
        if (datai_rd) begin
            iob_in = word;
        end else if (sel & iob_fm_status) begin
            iob_in = {30'b0, binary, busy_q, flag_q, pia_q};
        end
    end

    assign pi_req = pia_decode(pia_q, flag_q);

endmodule
